// File: rtl/ncl_pkg.sv
// ncl_pkg: shared definitions for the synchronous/NCL boundary blocks.
//   state_e      - transmitter handshake states
//   RAIL_*       - dual-rail encodings of one bit, packed as {t,f}
//   to_dual_rail - maps one single-rail bit to its DATA rail pair
package ncl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RTN  = 2'd2
    } state_e;

    localparam logic [1:0] RAIL_NULL = 2'b00;
    localparam logic [1:0] RAIL_0    = 2'b01;
    localparam logic [1:0] RAIL_1    = 2'b10;

    function automatic logic [1:0] to_dual_rail(input logic b);
        return b ? RAIL_1 : RAIL_0;
    endfunction

endpackage

// File: rtl/ncl_sync2.sv
// ncl_sync2: two-flop synchronizer for an asynchronous level (e.g. an NCL
// completion acknowledge). Output follows input after two rising edges.
//   clk  - system clock
//   rst  - synchronous active-high reset, clears both flops
//   d    - asynchronous input
//   q    - synchronized output
module ncl_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ncl_dr_tx.sv
// ncl_dr_tx: synchronous-to-NCL transmitter. Accepts single-rail words over
// a valid/ready handshake and drives them as whole-word dual-rail DATA
// wavefronts, followed by NULL, paced by the downstream acknowledge ki.
//   clk, rst        - clock, synchronous active-high reset
//   in_valid/ready  - source handshake; in_data captured on accept
//   dr_t / dr_f     - registered true/false rails
//   ki              - async acknowledge (1 = request data, 0 = request null)
//   err             - sticky watchdog timeout flag
//   tx_count        - completed DATA+NULL cycles, wrapping
module ncl_dr_tx
    import ncl_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] dr_t,
    output logic [WIDTH-1:0] dr_f,
    input  logic             ki,
    output logic             err,
    output logic [CNT_W-1:0] tx_count
);

    localparam int unsigned         WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]     WD_MAX = WD_W'(TIMEOUT);

    logic             ki_s;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] rail_t_q, rail_f_q;
    logic [WIDTH-1:0] rail_t_d, rail_f_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_data;
    logic             hold_data;
    logic             waiting;

    ncl_sync2 u_ki_sync (
        .clk (clk),
        .rst (rst),
        .d   (ki),
        .q   (ki_s)
    );

    // Next-state, counters and watchdog. A ki_s transition always takes
    // priority over the watchdog: when the state advances, waiting stays 0,
    // so the counter clears and err cannot be raised on that edge.
    always_comb begin
        state_d   = state_q;
        load_data = 1'b0;
        hold_data = 1'b0;
        waiting   = 1'b0;
        cnt_d     = cnt_q;
        err_d     = err_q;
        wd_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && ki_s) begin
                    state_d   = S_DATA;
                    load_data = 1'b1;
                end
            end
            S_DATA: begin
                if (!ki_s) begin
                    state_d = S_RTN;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    hold_data = 1'b1;
                    waiting   = 1'b1;
                end
            end
            S_RTN: begin
                if (ki_s) begin
                    state_d = S_IDLE;
                end else begin
                    waiting = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (waiting) begin
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            if (wd_d == WD_MAX) begin
                err_d = 1'b1;
            end
        end
    end

    // Per-bit rail selection: every bit takes the same branch, so the word
    // switches DATA<->NULL as a whole on a single edge.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rail
            logic [1:0] pair;
            always_comb begin
                pair = RAIL_NULL;
                if (load_data) begin
                    pair = to_dual_rail(in_data[gi]);
                end else if (hold_data) begin
                    pair = {rail_t_q[gi], rail_f_q[gi]};
                end
            end
            assign rail_t_d[gi] = pair[1];
            assign rail_f_d[gi] = pair[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rail_t_q <= '0;
            rail_f_q <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rail_t_q <= rail_t_d;
            rail_f_q <= rail_f_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Gated by rst so the source never sees ready while reset is applied,
    // even on the first reset cycle when ki_s may still be high.
    assign in_ready = !rst && (state_q == S_IDLE) && ki_s;
    assign dr_t     = rail_t_q;
    assign dr_f     = rail_f_q;
    assign err      = err_q;
    assign tx_count = cnt_q;

endmodule

// File: tb/tb_ncl_dr_tx.sv
module tb_ncl_dr_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] dr_t;
    logic [W-1:0] dr_f;
    logic         ki;
    logic         err;
    logic [15:0]  tx_count;

    logic         ki_man;
    logic         echo_en;
    logic         mon_en;

    int n_total;
    int n_pass;

    logic [2*W-1:0] sb[$];

    always #5 clk = ~clk;

    // Model downstream stage: when echoing, it requests data whenever the
    // rails are NULL and requests null as soon as a DATA word is present.
    assign ki = echo_en ? ~|(dr_t | dr_f) : ki_man;

    ncl_dr_tx #(.WIDTH(W), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .dr_t     (dr_t),
        .dr_f     (dr_f),
        .ki       (ki),
        .err      (err),
        .tx_count (tx_count)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s: got %0h", nm, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        sb.push_back({w, ~w});
    endtask

    task automatic push_null();
        sb.push_back('0);
    endtask

    task automatic wait_ready(input string nm, input int lim);
        int n = 0;
        while (!in_ready && n < lim) begin
            tick();
            n++;
        end
        check(nm, 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset(input logic k);
        rst    = 1'b1;
        ki_man = k;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Monitor: every rail change is a wavefront and is scored against the
    // next expected wavefront; overlapping rails fail immediately.
    logic [2*W-1:0] prev_rails;
    always @(negedge clk) begin
        if (mon_en) begin
            if (|(dr_t & dr_f)) begin
                n_total++;
                $display("FAIL rail_overlap: t=%b f=%b expected no bit with both rails", dr_t, dr_f);
            end
            if ({dr_t, dr_f} != prev_rails) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected: got %b expected no wavefront", {dr_t, dr_f});
                end else begin
                    check("sb_wavefront", 32'({dr_t, dr_f}), 32'(sb.pop_front()));
                end
            end
            prev_rails = {dr_t, dr_f};
        end
    end

    initial begin
        n_total    = 0;
        n_pass     = 0;
        mon_en     = 1'b0;
        prev_rails = '0;
        echo_en    = 1'b0;
        ki_man     = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        rst        = 1'b1;

        // 1. reset
        repeat (3) tick();
        mon_en = 1'b1;
        check("rst_dr_t", 32'(dr_t), 32'h0);
        check("rst_dr_f", 32'(dr_f), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tx_count", 32'(tx_count), 32'd0);
        rst = 1'b0;
        tick();
        check("rdy_after1", 32'(in_ready), 32'd0);
        tick();
        check("rdy_after2", 32'(in_ready), 32'd1);

        // 2. single word
        in_valid = 1'b1;
        in_data  = 4'b1010;
        push_word(4'b1010);
        tick();                           // accept edge T
        in_valid = 1'b0;
        in_data  = 4'b0110;
        check("t2_dr_t", 32'(dr_t), 32'b1010);
        check("t2_dr_f", 32'(dr_f), 32'b0101);
        tick();                           // T+1
        ki_man = 1'b0;
        tick();
        tick();                           // T+3
        check("t2_hold_dr_t", 32'(dr_t), 32'b1010);
        push_null();
        tick();                           // T+4
        check("t2_null", 32'({dr_t, dr_f}), 32'h0);
        check("t2_tx_count", 32'(tx_count), 32'd1);
        ki_man = 1'b1;
        tick();
        tick();
        check("t2_rdy_early", 32'(in_ready), 32'd0);
        tick();                           // 2 sync edges + RTN->IDLE edge
        check("t2_rdy", 32'(in_ready), 32'd1);

        // 3. back-to-back with echoing downstream
        do_reset(1'b1);
        echo_en = 1'b1;
        wait_ready("t3_rdy0", 5);
        push_word(4'b0000);
        push_null();
        push_word(4'b1111);
        push_null();
        in_valid = 1'b1;
        in_data  = 4'b0000;
        tick();
        in_valid = 1'b0;
        wait_ready("t3_rdy1", 20);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && tx_count != 16'd2; i++) tick();
        wait_ready("t3_rdy2", 20);
        check("t3_tx_count", 32'(tx_count), 32'd2);
        echo_en = 1'b0;

        // 4. backpressure: downstream never requests data
        do_reset(1'b0);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        begin
            int bad = 0;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (in_ready || dr_t != 0 || dr_f != 0 || err) bad++;
            end
            check("t4_bp_violations", 32'(bad), 32'd0);
        end
        check("t4_in_ready", 32'(in_ready), 32'd0);
        check("t4_err", 32'(err), 32'd0);
        check("t4_tx_count", 32'(tx_count), 32'd0);
        in_valid = 1'b0;

        // 5. watchdog timeout while ki stuck at 1 in DATA
        do_reset(1'b1);
        wait_ready("t5_rdy", 5);
        in_valid = 1'b1;
        in_data  = 4'b1010;
        push_word(4'b1010);
        tick();                           // T
        in_valid = 1'b0;
        repeat (7) tick();                // T+7
        check("t5_err_early", 32'(err), 32'd0);
        tick();                           // T+8
        check("t5_err", 32'(err), 32'd1);
        check("t5_still_data", 32'({dr_t, dr_f}), 32'b1010_0101);
        ki_man = 1'b0;
        push_null();
        repeat (3) tick();
        check("t5_null", 32'({dr_t, dr_f}), 32'h0);
        check("t5_tx_count", 32'(tx_count), 32'd1);
        check("t5_err_sticky", 32'(err), 32'd1);
        ki_man = 1'b1;
        wait_ready("t5_rdy_end", 5);

        // 6. reset in the middle of DATA
        do_reset(1'b1);
        wait_ready("t6_rdy", 5);
        in_valid = 1'b1;
        in_data  = 4'b1010;
        push_word(4'b1010);
        tick();
        in_valid = 1'b0;
        check("t6_data", 32'({dr_t, dr_f}), 32'b1010_0101);
        rst = 1'b1;
        push_null();
        tick();
        check("t6_null", 32'({dr_t, dr_f}), 32'h0);
        check("t6_tx_count", 32'(tx_count), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_rdy_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("t6_idle_rdy", 32'(in_ready), 32'd1);

        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
